// File: rtl/cache_ctrl_wb_2way_if.sv
// CPU load/store port and main-memory handshake port of the
// 2-way write-back cache controller.
interface cache_ctrl_wb_2way_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 14
);
    logic                  cpu_rd;
    logic                  cpu_wr;
    logic [ADDR_WIDTH-1:0] cpu_addr;
    logic [DATA_WIDTH-1:0] cpu_wdata;
    logic [DATA_WIDTH-1:0] cpu_rdata;
    logic                  cpu_ready;
    logic                  mem_rd;
    logic                  mem_wr;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  mem_ready;

    modport slave (
        input  cpu_rd, cpu_wr, cpu_addr, cpu_wdata,
        input  mem_rdata, mem_ready,
        output cpu_rdata, cpu_ready,
        output mem_rd, mem_wr, mem_addr, mem_wdata
    );

    modport master (
        output cpu_rd, cpu_wr, cpu_addr, cpu_wdata,
        output mem_rdata, mem_ready,
        input  cpu_rdata, cpu_ready,
        input  mem_rd, mem_wr, mem_addr, mem_wdata
    );
endinterface

// File: rtl/cache_ctrl_wb_2way.sv
// Controller FSM for a 2-way set-associative, write-back,
// write-allocate cache with one-word lines and one LRU bit per set.
module cache_ctrl_wb_2way #(
    parameter int DATA_WIDTH  = 16,
    parameter int TAG_WIDTH   = 6,
    parameter int INDEX_WIDTH = 8,
    parameter int ADDR_WIDTH  = TAG_WIDTH + INDEX_WIDTH,
    parameter int SETS        = 1 << INDEX_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    cache_ctrl_wb_2way_if.slave    bus,
    output logic                   tag_rd,
    output logic [1:0]             tag_wr,
    output logic [INDEX_WIDTH-1:0] index,
    output logic [TAG_WIDTH-1:0]   tagin,
    output logic                   dirty_wr,
    input  logic [TAG_WIDTH-1:0]   tagout0,
    input  logic [TAG_WIDTH-1:0]   tagout1,
    input  logic                   valid0,
    input  logic                   valid1,
    input  logic                   dirty0,
    input  logic                   dirty1,
    output logic [1:0]             data_wr,
    output logic [DATA_WIDTH-1:0]  data_in,
    input  logic [DATA_WIDTH-1:0]  data_out0,
    input  logic [DATA_WIDTH-1:0]  data_out1
);
    typedef enum logic [2:0] {
        IDLE, COMPARE, WRITEBACK, REFILL, ALLOC
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic                    opwr_q, opwr_d;
    logic                    vict_q, vict_d;
    logic [TAG_WIDTH-1:0]    vtag_q, vtag_d;
    logic [DATA_WIDTH-1:0]   vdata_q, vdata_d;
    logic [DATA_WIDTH-1:0]   fill_q, fill_d;
    logic [SETS-1:0]         lru_q;
    logic                    lru_we, lru_val;

    logic [INDEX_WIDTH-1:0]  idx;
    logic [TAG_WIDTH-1:0]    tag;
    logic                    hit0, hit1, hit_way;
    logic                    vict_c, vict_dirty;

    logic                    tag_rd_c, dirty_wr_c;
    logic [1:0]              tag_wr_c, data_wr_c;
    logic [INDEX_WIDTH-1:0]  index_c;
    logic [TAG_WIDTH-1:0]    tagin_c;
    logic [DATA_WIDTH-1:0]   data_in_c, rdata_c, mem_wdata_c;
    logic                    ready_c, mem_rd_c, mem_wr_c;
    logic [ADDR_WIDTH-1:0]   mem_addr_c;

    assign idx  = addr_q[INDEX_WIDTH-1:0];
    assign tag  = addr_q[ADDR_WIDTH-1:INDEX_WIDTH];
    assign hit0 = valid0 & (tagout0 == tag);
    assign hit1 = valid1 & (tagout1 == tag);
    // way0 wins if both ways ever match
    assign hit_way = ~hit0;
    assign vict_c  = !valid0 ? 1'b0 :
                     !valid1 ? 1'b1 : lru_q[idx];
    assign vict_dirty = vict_c ? (valid1 & dirty1)
                               : (valid0 & dirty0);

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        opwr_d      = opwr_q;
        vict_d      = vict_q;
        vtag_d      = vtag_q;
        vdata_d     = vdata_q;
        fill_d      = fill_q;
        lru_we      = 1'b0;
        lru_val     = 1'b0;
        tag_rd_c    = 1'b0;
        tag_wr_c    = '0;
        index_c     = '0;
        tagin_c     = '0;
        dirty_wr_c  = 1'b0;
        data_wr_c   = '0;
        data_in_c   = '0;
        rdata_c     = '0;
        ready_c     = 1'b0;
        mem_rd_c    = 1'b0;
        mem_wr_c    = 1'b0;
        mem_addr_c  = '0;
        mem_wdata_c = '0;
        unique case (state_q)
            IDLE: begin
                tag_rd_c = 1'b1;
                if (bus.cpu_rd | bus.cpu_wr) begin
                    addr_d  = bus.cpu_addr;
                    wdata_d = bus.cpu_wdata;
                    opwr_d  = bus.cpu_wr;
                    state_d = COMPARE;
                end
            end
            COMPARE: begin
                tag_rd_c = 1'b1;
                index_c  = idx;
                if (hit0 | hit1) begin
                    ready_c = 1'b1;
                    lru_we  = 1'b1;
                    lru_val = ~hit_way;
                    state_d = IDLE;
                    if (opwr_q) begin
                        tag_wr_c   = hit_way ? 2'b10 : 2'b01;
                        data_wr_c  = hit_way ? 2'b10 : 2'b01;
                        tagin_c    = tag;
                        dirty_wr_c = 1'b1;
                        data_in_c  = wdata_q;
                    end else begin
                        rdata_c = hit_way ? data_out1 : data_out0;
                    end
                end else begin
                    vict_d  = vict_c;
                    vtag_d  = vict_c ? tagout1 : tagout0;
                    vdata_d = vict_c ? data_out1 : data_out0;
                    if (vict_dirty) state_d = WRITEBACK;
                    else state_d = opwr_q ? ALLOC : REFILL;
                end
            end
            WRITEBACK: begin
                mem_wr_c    = 1'b1;
                mem_addr_c  = {vtag_q, idx};
                mem_wdata_c = vdata_q;
                if (bus.mem_ready) state_d = opwr_q ? ALLOC : REFILL;
            end
            REFILL: begin
                mem_rd_c   = 1'b1;
                mem_addr_c = addr_q;
                if (bus.mem_ready) begin
                    fill_d  = bus.mem_rdata;
                    state_d = ALLOC;
                end
            end
            ALLOC: begin
                index_c    = idx;
                tag_wr_c   = vict_q ? 2'b10 : 2'b01;
                data_wr_c  = vict_q ? 2'b10 : 2'b01;
                tagin_c    = tag;
                dirty_wr_c = opwr_q;
                data_in_c  = opwr_q ? wdata_q : fill_q;
                rdata_c    = opwr_q ? '0 : fill_q;
                ready_c    = 1'b1;
                lru_we     = 1'b1;
                lru_val    = ~vict_q;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            opwr_q  <= 1'b0;
            vict_q  <= 1'b0;
            vtag_q  <= '0;
            vdata_q <= '0;
            fill_q  <= '0;
            lru_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            opwr_q  <= opwr_d;
            vict_q  <= vict_d;
            vtag_q  <= vtag_d;
            vdata_q <= vdata_d;
            fill_q  <= fill_d;
            if (lru_we) lru_q[idx] <= lru_val;
        end
    end

    // outputs are forced low for as long as reset is held
    assign tag_rd        = rst & tag_rd_c;
    assign tag_wr        = rst ? tag_wr_c : '0;
    assign index         = rst ? index_c : '0;
    assign tagin         = rst ? tagin_c : '0;
    assign dirty_wr      = rst & dirty_wr_c;
    assign data_wr       = rst ? data_wr_c : '0;
    assign data_in       = rst ? data_in_c : '0;
    assign bus.cpu_rdata = rst ? rdata_c : '0;
    assign bus.cpu_ready = rst & ready_c;
    assign bus.mem_rd    = rst & mem_rd_c;
    assign bus.mem_wr    = rst & mem_wr_c;
    assign bus.mem_addr  = rst ? mem_addr_c : '0;
    assign bus.mem_wdata = rst ? mem_wdata_c : '0;
endmodule

// File: tb/tb_cache_ctrl_wb_2way.sv
// Bench for cache_ctrl_wb_2way: behavioural tag/data/main memories,
// a reference word memory and a scoreboard of expected completions.
module tb_cache_ctrl_wb_2way;
    logic        clk;
    logic        rst;
    logic        tag_rd, dirty_wr;
    logic [1:0]  tag_wr, data_wr;
    logic [7:0]  index;
    logic [5:0]  tagin, tagout0, tagout1;
    logic        valid0, valid1, dirty0, dirty1;
    logic [15:0] data_in, data_out0, data_out1;

    cache_ctrl_wb_2way_if #(.DATA_WIDTH(16), .ADDR_WIDTH(14)) bus ();

    cache_ctrl_wb_2way dut (
        .clk(clk), .rst(rst), .bus(bus),
        .tag_rd(tag_rd), .tag_wr(tag_wr), .index(index),
        .tagin(tagin), .dirty_wr(dirty_wr),
        .tagout0(tagout0), .tagout1(tagout1),
        .valid0(valid0), .valid1(valid1),
        .dirty0(dirty0), .dirty1(dirty1),
        .data_wr(data_wr), .data_in(data_in),
        .data_out0(data_out0), .data_out1(data_out1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // cache tag/data arrays
    logic [5:0]  tag_m   [2][256];
    logic        valid_m [2][256];
    logic        dirty_m [2][256];
    logic [15:0] data_m  [2][256];
    logic        mem_init;

    assign tagout0   = tag_rd ? tag_m[0][index] : '0;
    assign tagout1   = tag_rd ? tag_m[1][index] : '0;
    assign valid0    = tag_rd & valid_m[0][index];
    assign valid1    = tag_rd & valid_m[1][index];
    assign dirty0    = tag_rd & dirty_m[0][index];
    assign dirty1    = tag_rd & dirty_m[1][index];
    assign data_out0 = data_m[0][index];
    assign data_out1 = data_m[1][index];

    always @(posedge clk) begin
        if (mem_init) begin
            for (int s = 0; s < 256; s++) begin
                valid_m[0][s] <= 1'b0;
                valid_m[1][s] <= 1'b0;
                dirty_m[0][s] <= 1'b0;
                dirty_m[1][s] <= 1'b0;
                data_m[0][s]  <= '0;
                data_m[1][s]  <= '0;
                tag_m[0][s]   <= '0;
                tag_m[1][s]   <= '0;
            end
        end else begin
            for (int w = 0; w < 2; w++) begin
                if (tag_wr[w]) begin
                    tag_m[w][index]   <= tagin;
                    valid_m[w][index] <= 1'b1;
                    dirty_m[w][index] <= dirty_wr;
                end
                if (data_wr[w]) data_m[w][index] <= data_in;
            end
        end
    end

    function automatic logic [15:0] init_word(input logic [13:0] a);
        if (a == 14'h0105) return 16'hBEEF;
        return {2'b10, a} ^ 16'h0F0F;
    endfunction

    // main memory responder and bus monitor (3-cycle latency)
    logic [15:0] mm [16384];
    logic        seen_mrd, seen_mwr;
    logic [13:0] wb_addr_c;
    logic [15:0] wb_data_c;

    initial begin
        int cnt;
        cnt = 0;
        for (int i = 0; i < 16384; i++) mm[i] = init_word(14'(i));
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(negedge clk);
            chk("mem_rd_wr_exclusive", 32'(bus.mem_rd & bus.mem_wr), 0);
            if (!bus.cpu_ready)
                chk("cpu_rdata_idle_zero", 32'(bus.cpu_rdata), 0);
            if (bus.mem_rd) seen_mrd = 1'b1;
            if (bus.mem_wr && !seen_mwr) begin
                seen_mwr  = 1'b1;
                wb_addr_c = bus.mem_addr;
                wb_data_c = bus.mem_wdata;
            end
            if (!rst || bus.mem_ready) begin
                cnt = 0;
                bus.mem_ready = 1'b0;
                bus.mem_rdata = '0;
            end else if (bus.mem_rd || bus.mem_wr) begin
                cnt++;
                if (cnt == 3) begin
                    bus.mem_ready = 1'b1;
                    if (bus.mem_wr) mm[bus.mem_addr] = bus.mem_wdata;
                    else bus.mem_rdata = mm[bus.mem_addr];
                end
            end else begin
                cnt = 0;
            end
        end
    end

    typedef struct {
        int          op;
        logic [13:0] addr;
        logic [15:0] wdata;
        bit          hit;
        bit          mrd;
        bit          mwr;
        logic [13:0] wb_addr;
        logic [1:0]  twr;
    } vec_t;

    typedef struct {
        logic [15:0] rdata;
        logic [15:0] wbdata;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] ref_m [16384];

    // op: 0 read, 1 write, 2 read+write together
    task automatic apply(input vec_t v);
        exp_t e, got;
        int   lat;
        e.rdata  = (v.op == 0) ? ref_m[v.addr] : 16'h0;
        e.wbdata = ref_m[v.wb_addr];
        sb.push_back(e);
        if (v.op != 0) ref_m[v.addr] = v.wdata;
        seen_mrd      = 1'b0;
        seen_mwr      = 1'b0;
        bus.cpu_rd    = (v.op != 1);
        bus.cpu_wr    = (v.op != 0);
        bus.cpu_addr  = v.addr;
        bus.cpu_wdata = v.wdata;
        @(negedge clk);
        bus.cpu_rd = 1'b0;
        bus.cpu_wr = 1'b0;
        lat = 1;
        while (!bus.cpu_ready && lat < 64) begin
            @(negedge clk);
            lat++;
        end
        got = sb.pop_front();
        if (!bus.cpu_ready) begin
            chk("cpu_ready_timeout", 0, 1);
        end else begin
            chk("cpu_rdata", 32'(bus.cpu_rdata), 32'(got.rdata));
            chk("hit_latency", 32'(lat == 1), 32'(v.hit));
            chk("mem_rd_seen", 32'(seen_mrd), 32'(v.mrd));
            chk("mem_wr_seen", 32'(seen_mwr), 32'(v.mwr));
            if (v.mwr) begin
                chk("wb_addr", 32'(wb_addr_c), 32'(v.wb_addr));
                chk("wb_data", 32'(wb_data_c), 32'(got.wbdata));
            end
            chk("tag_wr", 32'(tag_wr), 32'(v.twr));
            chk("data_wr", 32'(data_wr), 32'(v.twr));
            if (v.twr != 2'b00) begin
                chk("tagin", 32'(tagin), 32'(v.addr[13:8]));
                chk("dirty_wr", 32'(dirty_wr), 32'(v.op != 0));
                chk("data_in", 32'(data_in),
                    32'((v.op != 0) ? v.wdata : got.rdata));
                chk("index", 32'(index), 32'(v.addr[7:0]));
            end
        end
        @(negedge clk);
    endtask

    vec_t vecs[18];
    vec_t hv;

    initial begin
        int w;
        vecs[0]  = '{0, 14'h0105, 16'h0000, 0, 1, 0, 14'h0000, 2'b01};
        vecs[1]  = '{0, 14'h0105, 16'h0000, 1, 0, 0, 14'h0000, 2'b00};
        vecs[2]  = '{1, 14'h0105, 16'h1234, 1, 0, 0, 14'h0000, 2'b01};
        vecs[3]  = '{0, 14'h0205, 16'h0000, 0, 1, 0, 14'h0000, 2'b10};
        vecs[4]  = '{0, 14'h0305, 16'h0000, 0, 1, 1, 14'h0105, 2'b01};
        vecs[5]  = '{1, 14'h0405, 16'h5A5A, 0, 0, 0, 14'h0000, 2'b10};
        vecs[6]  = '{0, 14'h0105, 16'h0000, 0, 1, 0, 14'h0000, 2'b01};
        vecs[7]  = '{0, 14'h0405, 16'h0000, 1, 0, 0, 14'h0000, 2'b00};
        vecs[8]  = '{0, 14'h0505, 16'h0000, 0, 1, 0, 14'h0000, 2'b01};
        vecs[9]  = '{0, 14'h0605, 16'h0000, 0, 1, 1, 14'h0405, 2'b10};
        vecs[10] = '{0, 14'h0107, 16'h0000, 0, 1, 0, 14'h0000, 2'b01};
        vecs[11] = '{0, 14'h0207, 16'h0000, 0, 1, 0, 14'h0000, 2'b10};
        vecs[12] = '{0, 14'h0107, 16'h0000, 1, 0, 0, 14'h0000, 2'b00};
        vecs[13] = '{0, 14'h0307, 16'h0000, 0, 1, 0, 14'h0000, 2'b10};
        vecs[14] = '{0, 14'h0107, 16'h0000, 1, 0, 0, 14'h0000, 2'b00};
        vecs[15] = '{0, 14'h0207, 16'h0000, 0, 1, 0, 14'h0000, 2'b10};
        vecs[16] = '{2, 14'h0605, 16'h7777, 1, 0, 0, 14'h0000, 2'b10};
        vecs[17] = '{0, 14'h0605, 16'h0000, 1, 0, 0, 14'h0000, 2'b00};
        for (int i = 0; i < 16384; i++) ref_m[i] = init_word(14'(i));

        rst           = 1'b0;
        mem_init      = 1'b1;
        bus.cpu_rd    = 1'b0;
        bus.cpu_wr    = 1'b0;
        bus.cpu_addr  = '0;
        bus.cpu_wdata = '0;
        seen_mrd      = 1'b0;
        seen_mwr      = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_tag_rd", 32'(tag_rd), 0);
        chk("rst_cpu_ready", 32'(bus.cpu_ready), 0);
        chk("rst_mem_rd", 32'(bus.mem_rd), 0);
        chk("rst_mem_wr", 32'(bus.mem_wr), 0);
        chk("rst_tag_wr", 32'(tag_wr), 0);
        mem_init = 1'b0;
        rst      = 1'b1;
        #1;
        chk("idle_tag_rd", 32'(tag_rd), 1);
        chk("idle_index", 32'(index), 0);
        @(negedge clk);

        for (int i = 0; i < 18; i++) apply(vecs[i]);

        // set 0x07 LRU -> 1, then build a dirty pair in set 0x09
        hv = '{0, 14'h0107, 16'h0000, 1, 0, 0, 14'h0000, 2'b00};
        apply(hv);
        hv = '{1, 14'h0109, 16'h1111, 0, 0, 0, 14'h0000, 2'b01};
        apply(hv);
        hv = '{1, 14'h0209, 16'h2222, 0, 0, 0, 14'h0000, 2'b10};
        apply(hv);

        bus.cpu_rd   = 1'b1;
        bus.cpu_addr = 14'h0309;
        @(negedge clk);
        bus.cpu_rd = 1'b0;
        w = 0;
        while (!bus.mem_wr && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("wb_started", 32'(bus.mem_wr), 1);
        chk("wb_started_addr", 32'(bus.mem_addr), 32'h0109);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_mem_wr", 32'(bus.mem_wr), 0);
        chk("arst_mem_addr", 32'(bus.mem_addr), 0);
        chk("arst_cpu_ready", 32'(bus.cpu_ready), 0);
        chk("arst_tag_rd", 32'(tag_rd), 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("arst_idle_tag_rd", 32'(tag_rd), 1);
        chk("arst_idle_mem_wr", 32'(bus.mem_wr), 0);
        @(negedge clk);
        chk("arst_mm_untouched", 32'(mm[14'h0109]), 32'(init_word(14'h0109)));

        // LRU[7] cleared: clean way0 is now the victim
        hv = '{0, 14'h0307, 16'h0000, 0, 1, 0, 14'h0000, 2'b01};
        apply(hv);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/cache_ctrl_wb_2way.md
Name: cache_ctrl_wb_2way

Overview:
- Controller FSM for a 2-way set-associative, write-back, write-allocate cache.
- Drives two write-back tag memories (one per way, each with valid and dirty bits and combinational read gated by rd) and two data-word memories.
- Keeps one LRU bit per set.
- Sits between the CPU load/store port and the main-memory handshake port. Lines are one word.

Parameters:
- DATA_WIDTH, 16, CPU/memory word width
- TAG_WIDTH, 6, tag field width
- INDEX_WIDTH, 8, set index width
- ADDR_WIDTH, TAG_WIDTH+INDEX_WIDTH (14), word address width
- SETS, 1<<INDEX_WIDTH (256), number of sets / LRU bits

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- cpu_rd  in  1  read request
- cpu_wr  in  1  write request
- cpu_addr  in  ADDR_WIDTH  {tag,index}
- cpu_wdata  in  DATA_WIDTH  store data
- cpu_rdata  out  DATA_WIDTH  load data, valid while cpu_ready
- cpu_ready  out  1  one-cycle completion pulse
- tag_rd  out  1  rd to both tag mems
- tag_wr  out  2  per-way tag write (bit0 = way0)
- index  out  INDEX_WIDTH  set index to tag and data mems
- tagin  out  TAG_WIDTH  tag written on tag_wr
- dirty_wr  out  1  dirty value written with tag_wr
- tagout0, tagout1  in  TAG_WIDTH  tags of way0/way1
- valid0, valid1  in  1  valid bits
- dirty0, dirty1  in  1  dirty bits
- data_wr  out  2  per-way data write
- data_in  out  DATA_WIDTH  data written on data_wr
- data_out0, data_out1  in  DATA_WIDTH  combinational data read per way
- mem_rd  out  1  main-memory read request
- mem_wr  out  1  main-memory write request
- mem_addr  out  ADDR_WIDTH  main-memory word address
- mem_wdata  out  DATA_WIDTH  write-back data
- mem_rdata  in  DATA_WIDTH  refill data, valid with mem_ready
- mem_ready  in  1  main-memory completion

Behaviour:
- States: IDLE, COMPARE, WRITEBACK, REFILL, ALLOC.
- rst low, at any time including mid-transaction:
  - state=IDLE; all LRU bits 0; latched address, data and op cleared.
  - Every output 0.
  - A pending memory request is dropped.
- IDLE:
  - tag_rd=1.
  - If cpu_rd|cpu_wr: latch addr, wdata and op (cpu_wr wins if both high), go COMPARE.
  - Requests outside IDLE are ignored; the CPU waits for cpu_ready before issuing the next request.
- COMPARE:
  - tag_rd=1, index=latched index.
  - hitN = validN & (tagoutN==latched tag). Both ways hitting is illegal; way0 wins.
  - Read hit: cpu_rdata=data_outN, cpu_ready=1, LRU[index] <= ~N, go IDLE. Latency 1 cycle after accept.
  - Write hit: tag_wr[N]=1, tagin=latched tag, dirty_wr=1, data_wr[N]=1, data_in=latched wdata, cpu_ready=1, LRU[index] <= ~N, go IDLE.
  - Miss, victim selection: way0 if !valid0, else way1 if !valid1, else LRU[index]. Latch victim way, tag and data.
  - Miss with victim valid & dirty: go WRITEBACK.
  - Miss otherwise: read goes REFILL, write goes ALLOC.
- WRITEBACK:
  - mem_wr=1, mem_addr={victim tag, index}, mem_wdata=victim data, all held stable.
  - On mem_ready: read goes REFILL, write goes ALLOC. mem_wr drops the following cycle.
- REFILL:
  - mem_rd=1, mem_addr=latched address, held stable.
  - On mem_ready: capture mem_rdata, go ALLOC.
- ALLOC (1 cycle):
  - tag_wr[victim]=1, tagin=latched tag, dirty_wr=op_is_write.
  - data_wr[victim]=1; data_in = latched wdata (write) or captured refill data (read).
  - cpu_rdata = refill data on read, 0 on write; cpu_ready=1.
  - LRU[index] <= ~victim; go IDLE.
- mem_rd and mem_wr are never high together. mem_ready sampled outside WRITEBACK/REFILL is ignored.
- Outputs not driven in a state are 0 (including cpu_rdata when cpu_ready=0).

Test Plan:
- Cold read: reset, cpu_rd addr 0x0105 -> COMPARE miss, no WRITEBACK; mem_rd with mem_addr=0x0105; mem_rdata=0xBEEF after 3 cycles -> ALLOC tag_wr=2'b01, tagin=0x01, dirty_wr=0; cpu_ready with cpu_rdata=0xBEEF. Re-read 0x0105 -> hit, cpu_ready 1 cycle after accept, no mem_rd.
- Write hit: cpu_wr 0x0105 data 0x1234 on resident line -> tag_wr[0]=1, dirty_wr=1, data_in=0x1234, cpu_ready in COMPARE, mem_rd/mem_wr stay 0.
- Dirty eviction: fill set 0x05 with tag 0x01 (dirty, way0) and tag 0x02 (way1, most recent); cpu_rd 0x0305 -> victim way0; mem_wr with mem_addr=0x0105, mem_wdata=0x1234; then mem_rd 0x0305; tag_wr=2'b01, tagin=0x03.
- Write miss, clean victim: cpu_wr 0x0405 data 0x5A5A, victim clean -> no mem_rd/mem_wr; ALLOC data_in=0x5A5A, dirty_wr=1.
- LRU alternation: fill both ways of set 0x07, read way0 -> next miss on set 0x07 evicts way1.
- Async reset mid-WRITEBACK: drop rst while mem_wr=1 -> mem_wr=0 immediately, state IDLE, cpu_ready=0, all LRU bits 0.
